// File: rtl/parity_frame_pkg.sv
// Shared types and constants for the parity frame transmitter.
package parity_frame_pkg;

  // Frame FSM states, in the order they occur on the line.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // Bits added around the payload: start, parity, stop.
  localparam int FRAME_OVERHEAD_BITS = 3;

  // Width of the per-bit hold counter; covers CLKS_PER_BIT up to 255.
  localparam int HOLD_CNT_W = 8;

  // Total frame length in bits for a given payload width (DATA_W + 3).
  function automatic int frame_bits(input int data_w);
    return data_w + FRAME_OVERHEAD_BITS;
  endfunction

endpackage

// File: rtl/parity_frame_tx_bit_timer.sv
// Bit-hold timer: pulses o_tick on the last cycle of each serial bit.
module bit_timer
  import parity_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [HOLD_CNT_W-1:0] LAST_CNT = HOLD_CNT_W'(CLKS_PER_BIT - 1);

  logic [HOLD_CNT_W-1:0] r_cnt;
  logic                  w_last;

  assign w_last = (r_cnt == LAST_CNT);
  assign o_tick = i_en && w_last;

  // Count hold cycles while a frame is active; restart at every bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || w_last) begin
      r_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignment so every register samples pre-edge values.
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start, DATA_W bits LSB first, parity, stop.
module parity_frame_tx
  import parity_frame_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              par_out,
  output logic              busy,
  output logic              done
);

  localparam int BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  state_e                r_state;
  state_e                w_state_next;
  logic [DATA_W-1:0]     r_shift;
  logic [DATA_W-1:0]     w_shift_next;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [BIT_CNT_W-1:0]  w_bit_cnt_next;
  logic                  r_par;
  logic                  w_par_next;
  logic                  r_tx;
  logic                  w_tx_next;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_accept;
  logic                  w_tick;
  logic                  w_timer_en;

  // A word is taken only while idle; anything offered mid-frame is ignored.
  assign w_accept   = valid && (r_state == IDLE);
  assign w_timer_en = (r_state != IDLE);

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_timer_en),
    .o_tick (w_tick)
  );

  // Next-state, shift register, bit counter, parity and line-level decode.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_par_next     = r_par;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = START;
          w_shift_next = din;
          w_par_next   = (^din) ^ PARITY_ODD;
        end
      end
      START: begin
        if (w_tick) w_state_next = DATA;
      end
      DATA: begin
        if (w_tick) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_next   = PARITY;
            w_bit_cnt_next = '0;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_tick) w_state_next = STOP;
      end
      STOP: begin
        if (w_tick) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase

    // The line level is that of the state being entered, so tx is a plain flop.
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      PARITY:  w_tx_next = w_par_next;
      default: w_tx_next = 1'b1;
    endcase
  end

  // State and registered outputs; reset parks the line high asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: tx resets to 1 so an asserted reset idles the line immediately.
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_par     <= w_par_next;
      r_tx      <= w_tx_next;
      r_ready   <= (w_state_next == IDLE);
      r_busy    <= (w_state_next != IDLE);
      r_done    <= (r_state == STOP) && w_tick;
    end
  end

  assign ready   = r_ready;
  assign tx      = r_tx;
  assign par_out = r_par;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Scoreboard bench for parity_frame_tx across three parameter sets.
module tb_parity_frame_tx;
  import parity_frame_pkg::*;

  localparam int DW = 4;
  localparam int N  = 3;  // 0: even/4 clk, 1: odd/4 clk, 2: even/1 clk

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  valid;
  logic [DW-1:0] din [N];
  logic [N-1:0]  ready, tx, par_out, busy, done;

  int errors = 0;
  int checks = 0;

  bit exp_q[$];   // expected line bits, one entry per frame bit
  bit par_q[$];   // expected parity per accepted frame

  always #5 clk = ~clk;

  parity_frame_tx #(.DATA_W(DW), .PARITY_ODD(1'b0), .CLKS_PER_BIT(4)) u_even (
    .clk(clk), .rst_n(rst_n), .din(din[0]), .valid(valid[0]), .ready(ready[0]),
    .tx(tx[0]), .par_out(par_out[0]), .busy(busy[0]), .done(done[0]));

  parity_frame_tx #(.DATA_W(DW), .PARITY_ODD(1'b1), .CLKS_PER_BIT(4)) u_odd (
    .clk(clk), .rst_n(rst_n), .din(din[1]), .valid(valid[1]), .ready(ready[1]),
    .tx(tx[1]), .par_out(par_out[1]), .busy(busy[1]), .done(done[1]));

  parity_frame_tx #(.DATA_W(DW), .PARITY_ODD(1'b0), .CLKS_PER_BIT(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .din(din[2]), .valid(valid[2]), .ready(ready[2]),
    .tx(tx[2]), .par_out(par_out[2]), .busy(busy[2]), .done(done[2]));

  function automatic int cpb(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic bit podd(input int k);
    return (k == 1);
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive a word on instance k and queue the frame it must produce.
  task automatic offer(input int k, input logic [DW-1:0] d);
    bit p;
    valid[k] = 1'b1;
    din[k]   = d;
    p = (^d) ^ podd(k);
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
    exp_q.push_back(p);
    exp_q.push_back(1'b1);
    par_q.push_back(p);
  endtask

  // Entered at the falling edge right after the accepting edge. Checks every
  // cycle of one frame, then the done cycle. abort_at stops after that cycle's
  // checks; pulse_at offers 4'hF for one cycle mid-frame.
  task automatic run_frame(input int k, input int abort_at, input int pulse_at);
    bit b;
    bit p;
    int cyc;
    cyc = 0;
    p = par_q.pop_front();
    for (int i = 0; i < frame_bits(DW); i++) begin
      b = exp_q.pop_front();
      for (int j = 0; j < cpb(k); j++) begin
        check($sformatf("u%0d tx bit%0d hold%0d", k, i, j), tx[k], b);
        check($sformatf("u%0d busy cyc%0d", k, cyc), busy[k], 1'b1);
        check($sformatf("u%0d ready cyc%0d", k, cyc), ready[k], 1'b0);
        check($sformatf("u%0d done cyc%0d", k, cyc), done[k], 1'b0);
        check($sformatf("u%0d par_out cyc%0d", k, cyc), par_out[k], p);
        if (cyc == abort_at) return;
        if (pulse_at >= 0 && cyc == pulse_at) begin
          valid[k] = 1'b1;
          din[k]   = 4'hF;
        end else if (pulse_at >= 0 && cyc == pulse_at + 1) begin
          valid[k] = 1'b0;
        end
        cyc++;
        @(negedge clk);
      end
    end
    check($sformatf("u%0d done pulse", k), done[k], 1'b1);
    check($sformatf("u%0d ready after stop", k), ready[k], 1'b1);
    check($sformatf("u%0d tx idle after stop", k), tx[k], 1'b1);
    check($sformatf("u%0d busy after stop", k), busy[k], 1'b0);
    check($sformatf("u%0d par_out held", k), par_out[k], p);
  endtask

  initial begin
    valid = '0;
    for (int k = 0; k < N; k++) din[k] = '0;

    // Reset values while rst_n is low.
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check($sformatf("u%0d reset tx", k), tx[k], 1'b1);
      check($sformatf("u%0d reset busy", k), busy[k], 1'b0);
      check($sformatf("u%0d reset done", k), done[k], 1'b0);
      check($sformatf("u%0d reset par_out", k), par_out[k], 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) check($sformatf("u%0d ready after reset", k), ready[k], 1'b1);

    // Even parity, 0101: parity 0, done 28 cycles after accept.
    offer(0, 4'b0101);
    @(negedge clk);
    valid[0] = 1'b0;
    run_frame(0, -1, -1);
    @(negedge clk);
    check("u0 done single cycle", done[0], 1'b0);

    // Even parity, 0111: parity 1.
    offer(0, 4'b0111);
    @(negedge clk);
    valid[0] = 1'b0;
    run_frame(0, -1, -1);
    @(negedge clk);

    // Odd parity, 0000: parity bit 1.
    offer(1, 4'b0000);
    @(negedge clk);
    valid[1] = 1'b0;
    run_frame(1, -1, -1);
    @(negedge clk);

    // Back-to-back with valid held: A then 3, one idle cycle between frames.
    offer(0, 4'hA);
    @(negedge clk);
    offer(0, 4'h3);
    run_frame(0, -1, -1);
    @(negedge clk);
    valid[0] = 1'b0;
    run_frame(0, -1, -1);
    @(negedge clk);
    check("u0 no third frame busy", busy[0], 1'b0);
    check("u0 no third frame tx", tx[0], 1'b1);
    check("u0 no third frame ready", ready[0], 1'b1);

    // valid pulsed with 4'hF mid-frame must be ignored.
    offer(0, 4'h5);
    @(negedge clk);
    valid[0] = 1'b0;
    run_frame(0, -1, 10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("u0 ignored pulse idle tx %0d", i), tx[0], 1'b1);
      check($sformatf("u0 ignored pulse idle busy %0d", i), busy[0], 1'b0);
    end

    // Reset during data bit 2 (line low there): line high at once, no done.
    offer(0, 4'b0011);
    @(negedge clk);
    valid[0] = 1'b0;
    run_frame(0, 13, -1);
    exp_q.delete();
    par_q.delete();
    #2 rst_n = 1'b0;
    #1;
    check("u0 async reset tx", tx[0], 1'b1);
    check("u0 async reset busy", busy[0], 1'b0);
    check("u0 async reset done", done[0], 1'b0);
    @(negedge clk);
    check("u0 reset held done", done[0], 1'b0);
    rst_n = 1'b1;
    offer(0, 4'b1100);   // accepted on the first edge after release
    @(negedge clk);
    valid[0] = 1'b0;
    run_frame(0, -1, -1);
    @(negedge clk);

    // One clock per bit, 1001: seven-cycle frame.
    offer(2, 4'b1001);
    @(negedge clk);
    valid[2] = 1'b0;
    run_frame(2, -1, -1);
    @(negedge clk);
    check("u2 done single cycle", done[2], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/parity_frame_tx.md
PARITY_FRAME_TX -- requirements
Module: parity_frame_tx

Interface
REQ-001 Parameter DATA_W, 4, payload width in bits.
REQ-002 Parameter PARITY_ODD, 0, parity sense: 0 = even, 1 = odd.
REQ-003 Parameter CLKS_PER_BIT, 4, clock cycles each serial bit is held; legal range 1..255.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 din  input  DATA_W  payload word, sampled only on accept.
REQ-007 valid  input  1  sender offers din this cycle.
REQ-008 ready  output  1  block can accept a word this cycle.
REQ-009 tx  output  1  serial line; idles high.
REQ-010 par_out  output  1  parity bit of the latched word; stable for the whole frame.
REQ-011 busy  output  1  frame in progress (any state other than IDLE).
REQ-012 done  output  1  one-cycle pulse when the stop bit completes.

Function
REQ-013 Frame order SHALL be: start (0), DATA_W data bits LSB first, parity bit, stop (1).
REQ-014 Each frame bit SHALL drive tx for exactly CLKS_PER_BIT cycles; frame length = (DATA_W+3)*CLKS_PER_BIT cycles.
REQ-015 Parity SHALL be XOR of all latched data bits, inverted when PARITY_ODD=1.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE->START on the edge where valid && ready; din latched into shift register and par_out updated on that edge.
REQ-018 START->DATA, DATA->PARITY (after DATA_W bits), PARITY->STOP, each on the last cycle of the current bit's hold time.
REQ-019 STOP->IDLE at the end of the stop-bit hold; done SHALL be high for exactly the cycle after that edge.
REQ-020 ready SHALL equal 1 only in IDLE; valid and din changes outside IDLE SHALL be ignored.
REQ-021 tx SHALL go low in the first cycle after accept (1-cycle latency from accept to start bit).
REQ-022 Back-to-back: with valid held high, the next word SHALL be accepted in the IDLE cycle following STOP, giving exactly one idle-high cycle between frames.
REQ-023 Bit counter SHALL count 0..DATA_W-1 and clear on entry to PARITY; hold-time counter SHALL clear on every bit boundary, no wrap beyond CLKS_PER_BIT-1.
REQ-024 Outputs SHALL be registered; tx glitch-free.

Reset
REQ-025 While rst_n=0: state=IDLE, tx=1, ready=1 (after reset release), busy=0, done=0, par_out=0, counters and shift register 0.
REQ-026 Reset asserted mid-frame SHALL force tx=1 immediately (asynchronously) and abandon the frame; no done pulse.
REQ-027 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-028 Shared package parity_frame_pkg SHALL hold the state enum and the frame-length constant (DATA_W+3).
REQ-029 One sub-module, bit_timer, SHALL generate the bit-boundary tick from CLKS_PER_BIT; FSM, shift register and parity logic live in the top.

Verification
REQ-030 Even, din=4'b0101 -> par_out=0; tx = 0,1,0,1,0,0,1 each held 4 cycles; done pulses 28 cycles after accept.
REQ-031 Even, din=4'b0111 -> par_out=1; tx = 0,1,1,1,0,1,1; PARITY_ODD=1 with din=4'b0000 -> parity bit 1.
REQ-032 valid held high with words 4'hA then 4'h3 -> two full frames, exactly one idle-high cycle between, ready high only in that cycle.
REQ-033 valid pulsed with din=4'hF during a frame -> ignored; current frame unchanged; no second frame.
REQ-034 rst_n low during DATA bit 2 -> tx=1 within the same cycle, busy=0, no done; next accept produces a clean frame.
REQ-035 CLKS_PER_BIT=1, din=4'b1001 -> 7-cycle frame 0,1,0,0,1,0,1 (even parity 0).
